uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 1: clk cycles per serial bit (1 = clk runs at the baud rate, 9600).
REQ-002 SHALL provide port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL provide port data  input  8  byte to transmit; sampled only on acceptance.
REQ-005 SHALL provide port data_valid  input  1  requester has a byte on data.
REQ-006 SHALL provide port ready  output  1  block can accept a byte this cycle.
REQ-007 SHALL provide port busy  output  1  a frame is on the line (shifter state not IDLE).
REQ-008 SHALL provide port tx  output  1  serial line, idle high, registered output.

Function
REQ-009 SHALL accept a byte on any rising edge where data_valid && ready; there SHALL be no other way to load a byte.
REQ-010 SHALL hold one accepted byte in a one-entry holding register; ready = holding register empty.
REQ-011 SHALL run the shifter FSM with states IDLE, START, DATA, [PARITY], STOP.
REQ-012 IDLE: tx=1; when the holding register is full, move it to the shift register, clear it, and go to START on the same edge.
REQ-013 START: tx=0 for CLKS_PER_BIT cycles, then DATA.
REQ-014 DATA: drive shift bits LSB first, each for CLKS_PER_BIT cycles; 3-bit bit index 0..7; after bit 7 go to PARITY (if compiled in) else STOP.
REQ-015 STOP: tx=1 for CLKS_PER_BIT cycles; on its last cycle, if the holding register is full, load it and go straight to START (no idle gap), else go to IDLE.
REQ-016 Baud counter SHALL be $clog2(CLKS_PER_BIT)+1 bits wide, reset to 0 on every state change and wrapping at CLKS_PER_BIT-1.
REQ-017 Latency: byte accepted at edge N with the FSM IDLE -> tx falls low after edge N+1; whole frame = 10*CLKS_PER_BIT cycles (11 with parity).
REQ-018 A byte accepted while a frame is in progress SHALL wait in the holding register; ready SHALL stay low until that byte moves to the shifter.
REQ-019 If the load into the shifter and a new acceptance fall on the same edge, the old byte SHALL go to the shifter and the new byte SHALL fill the holding register; no byte lost.
REQ-020 busy SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-021 data_valid while ready=0 SHALL be ignored; the requester holds data/data_valid until accepted.

Reset
REQ-022 On rst assertion, asynchronously: state=IDLE, tx=1, ready=1, busy=0, holding register empty, counters=0, shift register=8'd0.
REQ-023 Reset mid-frame SHALL abort the frame immediately (tx high) and discard both the shifted and the held byte.
REQ-024 The first edge after rst deasserts SHALL already be able to accept a byte.

Configuration
REQ-025 Macro UART_TX_PARITY_EN defined: SHALL insert the PARITY state after DATA, driving even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles; frame = 11 bits.
REQ-026 Macro UART_TX_PARITY_EN undefined: SHALL leave out the PARITY state and its logic; DATA goes directly to STOP; frame = 10 bits.

Verification
REQ-027 Reset mid-frame: rst pulsed during DATA of 0x00 -> tx=1, ready=1, busy=0 asynchronously; nothing sent after release.
REQ-028 CLKS_PER_BIT=1, 0x55 sent from IDLE -> tx over 10 cycles = 0,1,0,1,0,1,0,1,0,1; busy high those 10 cycles; then tx=1, busy=0.
REQ-029 Back-to-back: 0xA3 then 0x0F held valid -> 0x0F accepted during the 0xA3 frame; its start bit directly follows the 0xA3 stop bit; line = 0,1,1,0,0,0,1,0,1,1,0,1,1,1,1,0,0,0,0,1.
REQ-030 Backpressure: third byte valid while the shifter is busy and the holding register full -> ready=0, byte not accepted until the second frame's load edge.
REQ-031 UART_TX_PARITY_EN defined, 0xA3 -> parity bit 0; 0x07 -> parity bit 1; frame 11 cycles.
REQ-032 CLKS_PER_BIT=4, 0x80 -> each bit held exactly 4 cycles; bit 7 (1) in cycles 33-36 after the start bit begins; frame 40 cycles.

Source files
------------

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-entry holding register so frames can go out back to back.
// Define UART_TX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_tx #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       data_valid,
  output logic       ready,
  output logic       busy,
  output logic       tx
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  logic [7:0]    shift, shift_nxt;
  logic [7:0]    hold_data;
  logic          hold_full;
  logic          tx_q, tx_nxt;
  logic          cnt_last, accept, load;

  assign cnt_last = (cnt == CNT_LAST);
  assign accept   = data_valid && !hold_full;
  assign ready    = !hold_full;
  assign busy     = (state != IDLE);
  assign tx       = tx_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_idx;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (hold_full) begin
          load      = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        if (cnt_last) begin
          cnt_nxt   = '0;
          bit_nxt   = 3'd0;
          state_nxt = DATA;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DATA: begin
        if (cnt_last) begin
          cnt_nxt = '0;
          if (bit_idx == 3'd7) begin
            bit_nxt = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end else begin
            bit_nxt = bit_idx + 3'd1;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (cnt_last) begin
          cnt_nxt   = '0;
          state_nxt = STOP;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
`endif
      STOP: begin
        if (cnt_last) begin
          cnt_nxt = '0;
          // a waiting byte starts its frame with no idle gap
          if (hold_full) begin
            load      = 1'b1;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        bit_nxt   = 3'd0;
      end
    endcase
  end

  assign shift_nxt = load ? hold_data : shift;

  // tx is registered, so it is computed from the state being entered
  always_comb begin
    tx_nxt = 1'b1;
    case (state_nxt)
      START:  tx_nxt = 1'b0;
      DATA:   tx_nxt = shift_nxt[bit_nxt];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_nxt = ^shift_nxt;
`endif
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      shift   <= shift_nxt;
      tx_q    <= tx_nxt;
    end
  end

  // a load frees the slot; an acceptance on the same edge refills it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_data <= 8'd0;
      hold_full <= 1'b0;
    end else if (accept) begin
      hold_data <= data;
      hold_full <= 1'b1;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: one instance at 1 clk/bit, one at 4 clks/bit.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data, data4;
  logic       data_valid, dv4;
  logic       ready, busy, tx;
  logic       ready4, busy4, tx4;

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx #(.CLKS_PER_BIT(1)) dut (
    .clk(clk), .rst(rst), .data(data), .data_valid(data_valid),
    .ready(ready), .busy(busy), .tx(tx)
  );

  uart_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .data(data4), .data_valid(dv4),
    .ready(ready4), .busy(busy4), .tx(tx4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // expected line level for bit slot i of a frame carrying b
  function automatic logic fbit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
    if (i == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic [7:0] b, input string tag);
    data = b;
    data_valid = 1'b1;
    chk({tag, "_ready_pre"}, ready, 1'b1);
    tick();
    data_valid = 1'b0;
    chk({tag, "_ready_acc"}, ready, 1'b0);
    chk({tag, "_tx_acc"}, tx, 1'b1);
    for (int k = 0; k < FB; k++) begin
      tick();
      chk($sformatf("%s_tx%0d", tag, k), tx, fbit(b, k));
      chk($sformatf("%s_busy%0d", tag, k), busy, 1'b1);
    end
    tick();
    chk({tag, "_tx_end"}, tx, 1'b1);
    chk({tag, "_busy_end"}, busy, 1'b0);
    chk({tag, "_ready_end"}, ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation ran too long");
    $fatal(1);
  end

  initial begin
    logic [7:0] seq [3];
    int acc_at [3];
    int nxt;
    logic pre;

    rst = 1'b1;
    data = 8'd0; data_valid = 1'b0;
    data4 = 8'd0; dv4 = 1'b0;
    #2;
    chk("rst_tx", tx, 1'b1);
    chk("rst_ready", ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tx4", tx4, 1'b1);
    chk("rst_busy4", busy4, 1'b0);
    tick();
    tick();
    rst = 1'b0;

    // first edge after release accepts
    send1(8'h55, "b55");
    send1(8'h07, "b07");
    send1(8'hA3, "bA3");

    // back-to-back plus backpressure: A3, 0F, C5
    seq[0] = 8'hA3; seq[1] = 8'h0F; seq[2] = 8'hC5;
    acc_at[0] = -1; acc_at[1] = -1; acc_at[2] = -1;
    data = seq[0];
    data_valid = 1'b1;
    tick();
    chk("b2b_ready_acc", ready, 1'b0);
    nxt = 1;
    data = seq[1];
    for (int k = 0; k < 3*FB; k++) begin
      pre = data_valid && ready;
      tick();
      if (pre) begin
        acc_at[nxt] = k;
        nxt++;
        if (nxt < 3) data = seq[nxt];
        else data_valid = 1'b0;
      end
      chk($sformatf("b2b_tx%0d", k), tx, fbit(seq[k/FB], k%FB));
      chk($sformatf("b2b_busy%0d", k), busy, 1'b1);
      if (k == FB-2) chk("bp_ready", ready, 1'b0);
    end
    chki("acc_0F", acc_at[1], 1);
    chki("acc_C5", acc_at[2], FB+1);
    tick();
    chk("b2b_busy_end", busy, 1'b0);
    chk("b2b_tx_end", tx, 1'b1);

    // reset mid-frame with a second byte held
    data = 8'h00;
    data_valid = 1'b1;
    tick();
    data = 8'hFF;
    tick();
    tick();
    data_valid = 1'b0;
    tick();
    tick();
    chk("mid_tx_data", tx, 1'b0);
    chk("mid_busy", busy, 1'b1);
    chk("mid_ready", ready, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_tx", tx, 1'b1);
    chk("mid_rst_ready", ready, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk($sformatf("post_rst_tx%0d", k), tx, 1'b1);
      chk($sformatf("post_rst_busy%0d", k), busy, 1'b0);
    end

    // 4 clocks per bit, 0x80
    data4 = 8'h80;
    dv4 = 1'b1;
    tick();
    dv4 = 1'b0;
    chk("c4_tx_acc", tx4, 1'b1);
    chk("c4_ready_acc", ready4, 1'b0);
    for (int k = 0; k < 4*FB; k++) begin
      tick();
      chk($sformatf("c4_tx%0d", k), tx4, fbit(8'h80, k/4));
      chk($sformatf("c4_busy%0d", k), busy4, 1'b1);
    end
    tick();
    chk("c4_busy_end", busy4, 1'b0);
    chk("c4_tx_end", tx4, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
